store_buffer: RTL

- FIFO write buffer between the MEM-stage store path and the data memory write port.
- Accepts committed stores and retires them in order, one per cycle, to the memory write port whenever the MEM stage is not issuing a load.
- Forwards buffered data to loads that hit a pending address, so loads never see stale memory.
- Its write outputs drive the data memory's MemWrite_i, addr_i and write_data_i directly.

---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/store_buffer_match.sv | 32 +++
 rtl/store_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared widths and the entry record for the store buffer and its matcher.
// Pure declarations: no logic, no latency, no flow control.
package store_buf_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int SB_CNT_W  = $clog2(SB_DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// DEPTH-way address compare; youngest (closest behind tail) match wins.
// Purely combinational, zero latency, no backpressure.
module sb_match #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0]            key,
  input  logic [PTR_W-1:0]             tail,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = tail - PTR_W'(k);
      if (valid[slot] && (addr[slot] == key)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store write buffer with load forwarding; push-to-memory-write latency >= 1 cycle.
// Stalls stores when full (st_ready_o=0); drains only when no load; STORE_BUF_COALESCE_EN merges same-address stores.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         st_valid_i,
  input  logic [ADDR_W-1:0]            st_addr_i,
  input  logic [DATA_W-1:0]            st_data_i,
  output logic                         st_ready_o,
  input  logic                         ld_valid_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  output logic                         ld_hit_o,
  output logic [DATA_W-1:0]            ld_data_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t                  ent_q [DEPTH];
  logic [PTR_W-1:0]           head_q;
  logic [PTR_W-1:0]           tail_q;
  logic [CNT_W-1:0]           cnt_q;

  logic [DEPTH-1:0]             vld_vec;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_vec;
  logic                         empty;
  logic                         full;
  logic [PTR_W-1:0]             ld_idx;
  logic                         coalesce;
  logic [PTR_W-1:0]             co_idx;
  logic                         push;
  logic                         alloc;
  logic                         merge;

  always_comb begin
    vld_vec  = '0;
    addr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_vec[i]  = ent_q[i].valid;
      addr_vec[i] = ent_q[i].addr;
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  assign mem_we_o    = !empty && !ld_valid_i;
  assign mem_addr_o  = empty ? '0 : ent_q[head_q].addr;
  assign mem_wdata_o = empty ? '0 : ent_q[head_q].data;
  assign count_o     = cnt_q;

  sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ld_match (
    .valid (vld_vec),
    .addr  (addr_vec),
    .key   (ld_addr_i),
    .tail  (tail_q),
    .hit   (ld_hit_o),
    .idx   (ld_idx)
  );

  assign ld_data_o = ld_hit_o ? ent_q[ld_idx].data : '0;

`ifdef STORE_BUF_COALESCE_EN
  logic co_hit;

  sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_co_match (
    .valid (vld_vec),
    .addr  (addr_vec),
    .key   (st_addr_i),
    .tail  (tail_q),
    .hit   (co_hit),
    .idx   (co_idx)
  );

  // The head being written to memory this cycle must keep its data; allocate instead.
  assign coalesce = co_hit && !(mem_we_o && (co_idx == head_q));
`else
  assign coalesce = 1'b0;
  assign co_idx   = '0;
`endif

  assign st_ready_o = !full || coalesce;
  assign push       = st_valid_i && st_ready_o;
  assign alloc      = push && !coalesce;
  assign merge      = push && coalesce;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (mem_we_o) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      if (alloc) begin
        ent_q[tail_q] <= '{valid: 1'b1, addr: st_addr_i, data: st_data_i};
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (merge) begin
        ent_q[co_idx].data <= st_data_i;
      end
      cnt_q <= cnt_q + CNT_W'(alloc) - CNT_W'(mem_we_o);
    end
  end

endmodule
